// File: rtl/instr_exec_unit.sv
// Execution stage behind the instruction register: single-cycle ALU ops plus an
// iterative restoring divider for DIV/MOD, with a registered valid/ready result.

package instr_exec_pkg;
    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;
endpackage

// state  | meaning
// IDLE   | ready for a new instruction when the output register is free
// DIVIDE | one quotient bit per cycle, MSB first, OP_W iterations
// FIXUP  | apply signs to quotient/remainder and load the result register
module instr_exec_unit
    import instr_exec_pkg::*;
#(
    parameter int OP_W  = 32,
    parameter int RES_W = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  instruction_t            instruction_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [RES_W-1:0] result,
    output opcode_t                 result_opc,
    output logic                    div_by_zero,
    output logic                    busy
);

    localparam int CNT_W = $clog2(OP_W);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    accept;
    logic                    is_divmod;
    logic                    op_b_zero;
    logic                    start_div;
    logic                    load_single;
    logic                    dbz_single;

    logic [OP_W-1:0]         op_a;
    logic [OP_W-1:0]         op_b;
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] single_res;
    logic [OP_W-1:0]         abs_a;
    logic [OP_W-1:0]         abs_b;

    logic [OP_W-1:0]         quo;
    logic [OP_W-1:0]         rem;
    logic [OP_W-1:0]         divisor;
    logic [OP_W-1:0]         rem_nxt;
    logic [OP_W:0]           rem_shift;
    logic [OP_W:0]           trial;
    logic                    neg_q;
    logic                    neg_r;
    opcode_t                 div_opc;
    logic [CNT_W-1:0]        cnt;

    logic [RES_W-1:0]        q_mag;
    logic [RES_W-1:0]        r_mag;
    logic signed [RES_W-1:0] fix_res;

    assign accept = in_valid && in_ready;

    // Decode the incoming word and compute every single-cycle result.
    always_comb begin
        op_a       = instruction_word.op_a;
        op_b       = instruction_word.op_b;
        a_ext      = {{(RES_W-OP_W){op_a[OP_W-1]}}, op_a};
        b_ext      = {{(RES_W-OP_W){op_b[OP_W-1]}}, op_b};
        abs_a      = op_a[OP_W-1] ? (~op_a + 1'b1) : op_a;
        abs_b      = op_b[OP_W-1] ? (~op_b + 1'b1) : op_b;
        is_divmod  = (instruction_word.opc == DIV) || (instruction_word.opc == MOD);
        op_b_zero  = (op_b == '0);
        dbz_single = is_divmod && op_b_zero;
        start_div  = accept && is_divmod && !op_b_zero;
        // A zero divisor short-circuits to a single-cycle result of 0.
        load_single = accept && !start_div;
        single_res = '0;
        case (instruction_word.opc)
            PASSA:   single_res = a_ext;
            PASSB:   single_res = b_ext;
            ADD:     single_res = a_ext + b_ext;
            SUB:     single_res = a_ext - b_ext;
            MULT:    single_res = a_ext * b_ext;
            default: single_res = '0;
        endcase
    end

    // One restoring-division step and the final sign correction.
    always_comb begin
        rem_shift = {rem, quo[OP_W-1]};
        trial     = rem_shift - {1'b0, divisor};
        rem_nxt   = trial[OP_W] ? rem_shift[OP_W-1:0] : trial[OP_W-1:0];
        q_mag     = {{(RES_W-OP_W){1'b0}}, quo};
        r_mag     = {{(RES_W-OP_W){1'b0}}, rem};
        if (div_opc == MOD) begin
            fix_res = neg_r ? -r_mag : r_mag;
        end else begin
            fix_res = neg_q ? -q_mag : q_mag;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_div) state_nxt = DIVIDE;
            DIVIDE:  if (cnt == CNT_W'(OP_W-1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and divider activity.
    always_comb begin
        in_ready = reset_n && (state == IDLE) && (!out_valid || out_ready);
        busy     = (state != IDLE);
    end

    // Divider working registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div_opc <= ZERO;
            cnt     <= '0;
        end else if (start_div) begin
            quo     <= abs_a;
            rem     <= '0;
            divisor <= abs_b;
            neg_q   <= op_a[OP_W-1] ^ op_b[OP_W-1];
            neg_r   <= op_a[OP_W-1];
            div_opc <= instruction_word.opc;
            cnt     <= '0;
        end else if (state == DIVIDE) begin
            rem <= rem_nxt;
            quo <= {quo[OP_W-2:0], ~trial[OP_W]};
            cnt <= cnt + 1'b1;
        end
    end

    // Output register: loads on a single-cycle accept or at FIXUP, holds under backpressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            result_opc  <= ZERO;
            div_by_zero <= 1'b0;
        end else if (load_single) begin
            out_valid   <= 1'b1;
            result      <= single_res;
            result_opc  <= instruction_word.opc;
            div_by_zero <= dbz_single;
        end else if (state == FIXUP) begin
            out_valid   <= 1'b1;
            result      <= fix_res;
            result_opc  <= div_opc;
            div_by_zero <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed vector table, hand-written handshake and
// abort sequences, and randomized ops checked against an arithmetic model.

module tb_instr_exec_unit;
    import instr_exec_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    logic signed [63:0] result;
    opcode_t      result_opc;
    logic         div_by_zero;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    instr_exec_unit #(.OP_W(32), .RES_W(64)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .result_opc       (result_opc),
        .div_by_zero      (div_by_zero),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        opcode_t     opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic from the opcode definitions.
    function automatic void model(input opcode_t opc, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] r, output logic z);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        z  = 1'b0;
        r  = '0;
        case (opc)
            PASSA: r = sa;
            PASSB: r = sb;
            ADD:   r = sa + sb;
            SUB:   r = sa - sb;
            MULT:  r = sa * sb;
            DIV:   if (sb == 0) z = 1'b1; else r = sa / sb;
            MOD:   if (sb == 0) z = 1'b1; else r = sa % sb;
            default: r = '0;
        endcase
    endfunction

    // Issue one op at a negedge with out_ready=1; returns latency in edges and the result.
    task automatic do_op(input opcode_t opc, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output logic dbz,
                         output opcode_t ropc, output bit held_ok);
        int g;
        g = 0;
        in_valid = 1'b1;
        instruction_word.opc  = opc;
        instruction_word.op_a = a;
        instruction_word.op_b = b;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instruction_word.op_a = $urandom;
        instruction_word.op_b = $urandom;
        held_ok = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (out_valid !== 1'b1 && (busy !== 1'b1 || in_ready !== 1'b0)) held_ok = 1'b0;
        end while (out_valid !== 1'b1 && lat < 60);
        res  = result;
        dbz  = div_by_zero;
        ropc = result_opc;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] res;
        logic        dbz;
        opcode_t     ropc;
        bit          ok;
        bit          seen;
        logic [63:0] m_res;
        logic        m_dbz;
        opcode_t     r_opc;
        logic [31:0] ra, rb;

        vecs[0]  = '{ADD,   32'hFFFF_FFF1, 32'd7,          64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1};
        vecs[1]  = '{SUB,   32'd3,         32'd10,         64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1};
        vecs[2]  = '{MULT,  32'h7FFF_FFFF, 32'd2,          64'h0000_0000_FFFF_FFFE, 1'b0, 1};
        vecs[3]  = '{MULT,  32'hFFFF_FFFD, 32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1};
        vecs[4]  = '{PASSB, 32'd123,       32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
        vecs[5]  = '{PASSA, 32'h8000_0000, 32'd1,          64'hFFFF_FFFF_8000_0000, 1'b0, 1};
        vecs[6]  = '{ZERO,  32'd55,        32'd66,         64'h0,                   1'b0, 1};
        vecs[7]  = '{DIV,   32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34};
        vecs[8]  = '{MOD,   32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 34};
        vecs[9]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 1'b0, 34};
        vecs[10] = '{MOD,   32'd7,         32'hFFFF_FFFE,  64'h1,                   1'b0, 34};
        vecs[11] = '{DIV,   32'd9,         32'd0,          64'h0,                   1'b1, 1};
        vecs[12] = '{MOD,   32'd9,         32'd0,          64'h0,                   1'b1, 1};
        vecs[13] = '{ADD,   32'd1,         32'd1,          64'h2,                   1'b0, 1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instruction_word = '{opc: ZERO, op_a: 32'sd0, op_b: 32'sd0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 64'h0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_opc", result_opc, ZERO);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].opc, vecs[i].a, vecs[i].b, lat, res, dbz, ropc, ok);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_dbz", i), dbz, vecs[i].exp_dbz);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_opc", i), ropc, vecs[i].opc);
            if (vecs[i].exp_lat > 1) check($sformatf("vec%0d_busy_hold", i), ok, 1'b1);
        end
        @(negedge clk);
        check("drain_valid", out_valid, 1'b0);

        // Back-to-back ADD then SUB
        in_valid = 1'b1;
        instruction_word = '{opc: ADD, op_a: -32'sd15, op_b: 32'sd7};
        @(posedge clk);
        #1;
        instruction_word = '{opc: SUB, op_a: 32'sd3, op_b: 32'sd10};
        @(negedge clk);
        check("b2b_first_valid", out_valid, 1'b1);
        check("b2b_first_result", result, 64'hFFFF_FFFF_FFFF_FFF8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_result", result, 64'hFFFF_FFFF_FFFF_FFF9);
        @(negedge clk);
        check("b2b_drop_valid", out_valid, 1'b0);

        // Backpressure: result held, queued word waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instruction_word = '{opc: ADD, op_a: 32'sd4, op_b: 32'sd5};
        @(posedge clk);
        #1;
        instruction_word = '{opc: SUB, op_a: 32'sd20, op_b: 32'sd1};
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 64'd9 || in_ready !== 1'b0 || result_opc !== ADD) ok = 1'b0;
        end
        check("bp_hold", ok, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", out_valid, 1'b1);
        check("bp_next_result", result, 64'd19);
        check("bp_next_opc", result_opc, SUB);
        @(negedge clk);
        check("bp_drop_valid", out_valid, 1'b0);

        // Reset mid-divide aborts the operation
        in_valid = 1'b1;
        instruction_word = '{opc: DIV, op_a: 32'sd1000, op_b: 32'sd3};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_result", seen, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);

        // Randomized ops against the arithmetic model
        for (int k = 0; k < 150; k++) begin
            r_opc = opcode_t'($urandom_range(0, 7));
            ra = rand_operand();
            rb = rand_operand();
            model(r_opc, ra, rb, m_res, m_dbz);
            do_op(r_opc, ra, rb, lat, res, dbz, ropc, ok);
            check($sformatf("rnd%0d_result", k), res, m_res);
            check($sformatf("rnd%0d_dbz", k), dbz, m_dbz);
            check($sformatf("rnd%0d_opc", k), ropc, r_opc);
            check($sformatf("rnd%0d_latency", k), 64'(lat),
                  ((r_opc == DIV || r_opc == MOD) && rb != 0) ? 64'd34 : 64'd1);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
